hwpe_stream_upsizer: RTL and testbench
======================================

HWPE_STREAM_UPSIZER -- requirements
Module: hwpe_stream_upsizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_IN, default 32, giving the narrow input stream data width (multiple of 8).
REQ-002 SHALL have parameter RATIO, default 4, giving the number of narrow beats packed per wide beat (legal range 2..16).
REQ-003 SHALL have port clk_i, input, 1 bit: clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous soft clear, active-high.
REQ-006 SHALL have port flush_i, input, 1 bit: single-cycle request to emit the current partial word.
REQ-007 SHALL have port flags_o, output, flags_upsizer_t: beat_cnt, flush_pending and out_valid status.
REQ-008 SHALL have port push_i, HWPE-Stream sink, DATA_WIDTH_IN data plus DATA_WIDTH_IN/8 strb: narrow input.
REQ-009 SHALL have port pop_o, HWPE-Stream source, DATA_WIDTH_IN*RATIO data plus matching strb: wide output, typically feeding a FIFO.

Function
REQ-010 SHALL accept a narrow beat on a cycle where push_i.valid and push_i.ready are both 1, and only then.
REQ-011 SHALL place the k-th accepted beat of a word (k = cnt_q, 0-based) in data lane [k*DATA_WIDTH_IN +: DATA_WIDTH_IN] and its strb in lane [k*DATA_WIDTH_IN/8 +: DATA_WIDTH_IN/8], with beat 0 in the LSBs.
REQ-012 SHALL use counter cnt_q, width $clog2(RATIO): incremented on each accepted beat, wrapping RATIO-1 -> 0 on word completion.
REQ-013 SHALL, on word completion, copy accumulator to the output register and set out_valid_q in the following cycle: latency of 1 cycle from the last narrow handshake to pop_o.valid.
REQ-014 SHALL drive pop_o.valid = out_valid_q, registered, with no combinational path from push_i.
REQ-015 SHALL clear out_valid_q on the cycle after pop_o.valid and pop_o.ready are both 1, unless a new word loads in the same cycle, in which case it stays 1 with new data.
REQ-016 SHALL drive push_i.ready = 0 when (cnt_q == RATIO-1 and out_valid_q == 1) or flush_pending_q == 1, and 1 otherwise; push_i.ready SHALL NOT depend combinationally on pop_o.ready.
REQ-017 SHALL sustain one narrow beat per cycle when pop_o.ready is held at 1.
REQ-018 SHALL hold pop_o.data/strb stable while pop_o.valid = 1 and pop_o.ready = 0.
REQ-019 SHALL drive pop_o.data and pop_o.strb to 0 when pop_o.valid = 0.
REQ-020 SHALL set flush_pending_q when flush_i = 1 and a partial word exists (cnt_q > 0 after the accepted beat of that cycle, if any).
REQ-021 SHALL ignore flush_i when no partial word exists, including when that cycle's beat completes a word.
REQ-022 SHALL include a beat accepted in the same cycle as flush_i in the flushed word.
REQ-023 SHALL, when flush_pending_q = 1 and out_valid_q = 0, load the partial word into the output register with unfilled lanes' data and strb = 0, reset cnt_q to 0, and clear flush_pending_q.
REQ-024 SHALL leave flush_pending_q set while out_valid_q = 1, so that the flush completes after the pending pop.
REQ-025 SHALL have clear_i = 1 zero cnt_q, accumulator, output register, out_valid_q and flush_pending_q on the next edge, with priority over push, pop and flush.
REQ-026 SHALL drive flags_o.beat_cnt = cnt_q, flags_o.flush_pending = flush_pending_q and flags_o.out_valid = out_valid_q.

Reset
REQ-027 SHALL, on rst_ni = 0, asynchronously set cnt_q = 0, accumulator = 0, output register = 0, out_valid_q = 0 and flush_pending_q = 0.
REQ-028 SHALL, during and right after reset, present pop_o.valid = 0, pop_o.data/strb = 0, push_i.ready = 1 and all flags_o fields = 0.
REQ-029 SHALL discard a partial word without emitting it when reset is asserted mid-word.

Structure
REQ-030 SHALL define flags_upsizer_t (beat_cnt logic[3:0], flush_pending, out_valid) in hwpe_stream_package.
REQ-031 SHALL be a single module with no sub-modules; the accumulator and output register are flip-flops.

Verification
REQ-032 Bench SHALL check streaming: RATIO=4, W=32, beats 0x11,0x22,0x33,0x44 back-to-back with pop_o.ready=1 -> one cycle after the 4th beat, data=0x00000044_00000033_00000022_00000011 and strb=0xFFFF.
REQ-033 Bench SHALL check backpressure: pop_o.ready=0 with 8 beats offered -> push_i.ready drops at cnt_q=3, word 1 held stable; raising pop_o.ready -> both words delivered in order, no loss.
REQ-034 Bench SHALL check flush: 2 beats 0xA,0xB then flush_i -> wide word with lanes 0,1 = 0xA,0xB, lanes 2,3 data=0, strb=0x00FF, cnt_q returns to 0.
REQ-035 Bench SHALL check flush with busy output: flush_i while out_valid_q=1 and pop_o.ready=0 -> flush_pending=1 and push_i.ready=0 until pop; partial word emitted the cycle after the pop.
REQ-036 Bench SHALL check simultaneous events: flush_i on the 4th beat's cycle -> normal full word and flush_pending stays 0; flush_i with cnt_q=0 and no beat -> no output.
REQ-037 Bench SHALL check clear/reset mid-word: clear_i after 3 beats -> next 4 beats form a clean word; rst_ni low mid-word -> all outputs 0 as in REQ-028.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// Shared HWPE-Stream types: the status flags the upsizer exposes.
package hwpe_stream_package;

  typedef struct packed {
    logic [3:0] beat_cnt;
    logic       flush_pending;
    logic       out_valid;
  } flags_upsizer_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE-Stream handshake bundle: valid/ready with data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_upsizer.sv
// Packs RATIO narrow beats into one wide beat, LSB lane first; wide word is valid 1 cycle after its last beat.
// Input stalls only when the final beat would overwrite an unpopped word, or while a flush is pending.
module hwpe_stream_upsizer
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH_IN = 32,
  parameter int unsigned RATIO         = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          flush_i,
  output flags_upsizer_t                flags_o,
  hwpe_stream_intf_stream.sink          push_i,
  hwpe_stream_intf_stream.source        pop_o
);

  localparam int unsigned STRB_IN  = DATA_WIDTH_IN / 8;
  localparam int unsigned DATA_OUT = DATA_WIDTH_IN * RATIO;
  localparam int unsigned STRB_OUT = STRB_IN * RATIO;
  localparam int unsigned CNT_W    = $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_OUT-1:0] acc_data_q, acc_data_d;
  logic [STRB_OUT-1:0] acc_strb_q, acc_strb_d;
  logic [DATA_OUT-1:0] out_data_q, out_data_d;
  logic [STRB_OUT-1:0] out_strb_q, out_strb_d;
  logic                out_valid_q, out_valid_d;
  logic                flush_pending_q, flush_pending_d;

  logic push_rdy, push_hs, pop_hs, word_done, flush_load;

  // Ready depends only on registered state, so no path from pop_o.ready.
  assign push_rdy   = ~(((cnt_q == CNT_LAST) && out_valid_q) || flush_pending_q);
  assign push_hs    = push_i.valid & push_rdy;
  assign pop_hs     = out_valid_q & pop_o.ready;
  assign word_done  = push_hs && (cnt_q == CNT_LAST);
  assign flush_load = flush_pending_q & ~out_valid_q;

  always_comb begin
    cnt_d           = cnt_q;
    acc_data_d      = acc_data_q;
    acc_strb_d      = acc_strb_q;
    out_data_d      = out_data_q;
    out_strb_d      = out_strb_q;
    out_valid_d     = out_valid_q;
    flush_pending_d = flush_pending_q;

    if (pop_hs) out_valid_d = 1'b0;

    if (push_hs) begin
      acc_data_d[cnt_q*DATA_WIDTH_IN +: DATA_WIDTH_IN] = push_i.data;
      acc_strb_d[cnt_q*STRB_IN +: STRB_IN]             = push_i.strb;
      cnt_d = word_done ? '0 : cnt_q + 1'b1;
    end

    // Accumulator is zeroed after each hand-off so a flushed word has empty upper lanes.
    if (word_done || flush_load) begin
      out_data_d  = acc_data_d;
      out_strb_d  = acc_strb_d;
      out_valid_d = 1'b1;
      acc_data_d  = '0;
      acc_strb_d  = '0;
      cnt_d       = '0;
    end

    if (flush_load)
      flush_pending_d = 1'b0;
    else if (flush_i && (cnt_d != '0))
      flush_pending_d = 1'b1;

    if (clear_i) begin
      cnt_d           = '0;
      acc_data_d      = '0;
      acc_strb_d      = '0;
      out_data_d      = '0;
      out_strb_d      = '0;
      out_valid_d     = 1'b0;
      flush_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q           <= '0;
      acc_data_q      <= '0;
      acc_strb_q      <= '0;
      out_data_q      <= '0;
      out_strb_q      <= '0;
      out_valid_q     <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      acc_data_q      <= acc_data_d;
      acc_strb_q      <= acc_strb_d;
      out_data_q      <= out_data_d;
      out_strb_q      <= out_strb_d;
      out_valid_q     <= out_valid_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign push_i.ready = push_rdy;
  assign pop_o.valid  = out_valid_q;
  assign pop_o.data   = out_valid_q ? out_data_q : '0;
  assign pop_o.strb   = out_valid_q ? out_strb_q : '0;

  assign flags_o.beat_cnt      = 4'(cnt_q);
  assign flags_o.flush_pending = flush_pending_q;
  assign flags_o.out_valid     = out_valid_q;

endmodule

// File: tb/tb_hwpe_stream_upsizer.sv
// Directed bench for the 32->128 bit upsizer with a wide-word scoreboard.
module tb_hwpe_stream_upsizer;
  import hwpe_stream_package::*;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  s;
  } word_t;

  logic           clk_i = 1'b0;
  logic           rst_ni, clear_i, flush_i;
  flags_upsizer_t flags;
  int             n_assert = 0;
  int             n_fail   = 0;
  int             cyc      = 0;
  word_t          sb[$];

  hwpe_stream_intf_stream #(.DATA_WIDTH(32))  push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(128)) pop_if ();

  hwpe_stream_upsizer #(.DATA_WIDTH_IN(32), .RATIO(4)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .flush_i (flush_i),
    .flags_o (flags),
    .push_i  (push_if),
    .pop_o   (pop_if)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic word_t mk4(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d);
    word_t w;
    w.d = {d, c, b, a};
    w.s = 16'hFFFF;
    return w;
  endfunction

  task automatic send_beat(input logic [31:0] d);
    bit got = 1'b0;
    push_if.valid = 1'b1;
    push_if.data  = d;
    push_if.strb  = 4'hF;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      got = push_if.ready;
    end
    chk("beat_accept", {127'b0, got}, 128'd1);
    tick();
    push_if.valid = 1'b0;
    push_if.data  = '0;
    push_if.strb  = '0;
  endtask

  // Every wide handshake is matched against the oldest expected word.
  always @(negedge clk_i) begin
    if (rst_ni && pop_if.valid && pop_if.ready) begin
      chk("sb_nonempty", {127'b0, sb.size() != 0}, 128'd1);
      if (sb.size() != 0) begin
        word_t e;
        e = sb.pop_front();
        chk("pop_data", pop_if.data, e.d);
        chk("pop_strb", {112'b0, pop_if.strb}, {112'b0, e.s});
      end
    end
  end

  initial begin
    word_t w1, w2;
    int    c0;

    rst_ni = 1'b0; clear_i = 1'b0; flush_i = 1'b0;
    push_if.valid = 1'b0; push_if.data = '0; push_if.strb = '0;
    pop_if.ready = 1'b0;

    // Reset values, during and right after reset
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", {127'b0, pop_if.valid}, 128'd0);
    chk("rst_data", pop_if.data, 128'd0);
    chk("rst_ready", {127'b0, push_if.ready}, 128'd1);
    chk("rst_flags", {122'b0, flags}, 128'd0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_strb", {112'b0, pop_if.strb}, 128'd0);
    chk("post_rst_flags", {122'b0, flags}, 128'd0);
    tick();

    // Streaming: wide word valid one cycle after the 4th beat
    pop_if.ready = 1'b1;
    w1 = mk4(32'h11, 32'h22, 32'h33, 32'h44);
    sb.push_back(w1);
    send_beat(32'h11); send_beat(32'h22); send_beat(32'h33); send_beat(32'h44);
    @(negedge clk_i);
    chk("stream_valid", {127'b0, pop_if.valid}, 128'd1);
    chk("stream_data", pop_if.data, 128'h00000044_00000033_00000022_00000011);
    chk("stream_strb", {112'b0, pop_if.strb}, 128'hFFFF);
    chk("stream_cnt", {124'b0, flags.beat_cnt}, 128'd0);
    tick();

    // Sustained throughput: 8 beats in 8 cycles
    sb.push_back(mk4(32'h55, 32'h66, 32'h77, 32'h88));
    sb.push_back(mk4(32'h99, 32'hAA, 32'hBB, 32'hCC));
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_beat(32'h55 + 32'(i) * 32'h11);
    chk("throughput_cycles", 128'(cyc - c0), 128'd8);
    repeat (2) tick();
    chk("stream_drained", 128'(sb.size()), 128'd0);

    // Backpressure: second word stalls at its last beat, first word held
    pop_if.ready = 1'b0;
    w1 = mk4(32'h101, 32'h102, 32'h103, 32'h104);
    w2 = mk4(32'h105, 32'h106, 32'h107, 32'h108);
    sb.push_back(w1);
    sb.push_back(w2);
    for (int i = 0; i < 7; i++) send_beat(32'h101 + 32'(i));
    push_if.valid = 1'b1; push_if.data = 32'h108; push_if.strb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_ready_low", {127'b0, push_if.ready}, 128'd0);
      chk("bp_hold_data", pop_if.data, w1.d);
    end
    chk("bp_cnt", {124'b0, flags.beat_cnt}, 128'd3);
    tick();
    pop_if.ready = 1'b1;
    send_beat(32'h108);
    repeat (3) tick();
    chk("bp_drained", 128'(sb.size()), 128'd0);

    // Flush of a two-beat partial word
    sb.push_back('{d: {64'h0, 32'hB, 32'hA}, s: 16'h00FF});
    send_beat(32'hA); send_beat(32'hB);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_pending", {127'b0, flags.flush_pending}, 128'd1);
    chk("flush_ready_low", {127'b0, push_if.ready}, 128'd0);
    tick();
    @(negedge clk_i);
    chk("flush_valid", {127'b0, pop_if.valid}, 128'd1);
    chk("flush_cnt_zero", {124'b0, flags.beat_cnt}, 128'd0);
    chk("flush_pending_clr", {127'b0, flags.flush_pending}, 128'd0);
    tick();

    // Flush while the output register is busy
    pop_if.ready = 1'b0;
    w1 = mk4(32'h201, 32'h202, 32'h203, 32'h204);
    sb.push_back(w1);
    sb.push_back('{d: {96'h0, 32'h205}, s: 16'h000F});
    for (int i = 0; i < 5; i++) send_beat(32'h201 + 32'(i));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("busy_pending", {127'b0, flags.flush_pending}, 128'd1);
      chk("busy_ready_low", {127'b0, push_if.ready}, 128'd0);
      chk("busy_hold", pop_if.data, w1.d);
      tick();
    end
    pop_if.ready = 1'b1;
    tick();
    @(negedge clk_i);
    chk("busy_gap_valid", {127'b0, pop_if.valid}, 128'd0);
    chk("busy_gap_data", pop_if.data, 128'd0);
    chk("busy_still_pending", {127'b0, flags.flush_pending}, 128'd1);
    tick();
    @(negedge clk_i);
    chk("busy_partial_valid", {127'b0, pop_if.valid}, 128'd1);
    tick();

    // Flush coinciding with the completing beat, then flush with nothing buffered
    sb.push_back(mk4(32'h301, 32'h302, 32'h303, 32'h304));
    send_beat(32'h301); send_beat(32'h302); send_beat(32'h303);
    flush_i = 1'b1;
    send_beat(32'h304);
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("sim_no_pending", {127'b0, flags.flush_pending}, 128'd0);
    chk("sim_full_valid", {127'b0, pop_if.valid}, 128'd1);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("empty_flush_pending", {127'b0, flags.flush_pending}, 128'd0);
      chk("empty_flush_valid", {127'b0, pop_if.valid}, 128'd0);
      tick();
    end

    // Soft clear with a held word and a 3-beat partial
    pop_if.ready = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(32'h401 + 32'(i));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("clr_flags", {122'b0, flags}, 128'd0);
    chk("clr_data", pop_if.data, 128'd0);
    chk("clr_ready", {127'b0, push_if.ready}, 128'd1);
    tick();
    pop_if.ready = 1'b1;
    sb.push_back(mk4(32'h501, 32'h502, 32'h503, 32'h504));
    for (int i = 0; i < 4; i++) send_beat(32'h501 + 32'(i));
    repeat (2) tick();

    // Asynchronous reset mid-word
    send_beat(32'h5A); send_beat(32'h5B);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {127'b0, pop_if.valid}, 128'd0);
    chk("mid_rst_data", pop_if.data, 128'd0);
    chk("mid_rst_ready", {127'b0, push_if.ready}, 128'd1);
    chk("mid_rst_flags", {122'b0, flags}, 128'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    sb.push_back(mk4(32'h601, 32'h602, 32'h603, 32'h604));
    for (int i = 0; i < 4; i++) send_beat(32'h601 + 32'(i));
    repeat (4) tick();
    chk("final_sb_empty", 128'(sb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
